divider_param: RTL and testbench
================================

Name: divider_param

Overview:
- Parametrised iterative radix-2 restoring divider for the execute-stage multicycle unit. It is the next generation of the fixed 32-bit divider.
- Adds generic WIDTH and optional early-out that skips leading zero dividend bits.
- Latches operands at start, so the pipeline may change them mid-operation.
- Adds a defined divide-by-zero result with flag, and a busy indicator.

Parameters:
WIDTH, 32, operand width in bits (>=4); quotient and remainder each WIDTH bits
EARLY_OUT, 1, 1 = skip iterations for leading zeros of |dividend|; 0 = always WIDTH iterations

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled in IDLE; must stay high until ready observed
abandon  in  1  synchronous cancel (pipeline flush/exception)
signdiv  in  1  1 = signed two's-complement division, sampled with start
opr1  in  WIDTH  dividend, sampled with start
opr2  in  WIDTH  divisor, sampled with start
ready  out  1  result valid
busy  out  1  high in every state except IDLE
dbz  out  1  divide-by-zero flag, valid while ready
res  out  2*WIDTH  {remainder, quotient}, valid while ready, zero otherwise

Behaviour:
- Reset (rst low, any time, asynchronous): state IDLE; ready=0, busy=0, dbz=0, res=0; all internal registers cleared. An in-flight operation is lost.
- Priority per edge: reset > abandon > state logic.
- abandon=1 in any state, start ignored: next state IDLE; ready, dbz, res cleared; no result is produced.
- States:
  - IDLE: on start=1, latch |opr1|, |opr2|, sign of opr1, sign of opr2 and signdiv (magnitudes only if signdiv=1), then go to PREP. Outputs are held at zero.
  - PREP, 1 cycle:
    - Divisor magnitude zero: set dbz, go to FIX.
    - Otherwise: s = clz(|dividend|) if EARLY_OUT=1, else 0 (clz(0)=WIDTH). Preshift the dividend left by s, set cnt=s.
    - Go to RUN if s<WIDTH, else go to FIX.
  - RUN: one restoring step per cycle on a WIDTH+1-bit partial remainder. If the partial remainder minus the divisor is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0. cnt increments; after the step where cnt reaches WIDTH, go to FIX.
  - FIX, 1 cycle:
    - Normal case: quotient negated if signed and operand signs differ; remainder negated if signed and dividend negative.
    - Divide-by-zero: quotient = all ones, remainder = original opr1, independent of signdiv.
    - Register res, set ready=1, go to DONE.
  - DONE: hold res, dbz and ready=1 while start=1. When start=0, go to IDLE and clear ready, dbz and res on that edge.
- Latency: with the start-sampling edge as edge 0, ready rises on edge N = WIDTH - s + 2. Divide-by-zero gives N=2.
- Signed overflow MIN / -1 yields quotient MIN, remainder 0, with no flag. This falls out of magnitude arithmetic; the magnitude of MIN fits in WIDTH unsigned bits.
- Results satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor| and quotient truncated toward zero.
- busy=1 from edge 0 until return to IDLE.
- Input changes on opr1, opr2 or signdiv after edge 0 have no effect.

Test Plan:
- Unsigned, WIDTH=32, EARLY_OUT=0: 100 / 7 → res={2, 14}, dbz=0, ready on edge 34; holds while start=1; clears one edge after start drops.
- Early-out, EARLY_OUT=1: 100 / 7 (clz=25) → same result, ready on edge 9. Dividend 0 / 3 → res=0, ready on edge 2.
- Signed: -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. 7 / -2 → quotient 0xFFFFFFFD, remainder 1. 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide-by-zero: 5 / 0, signed and unsigned → dbz=1, quotient 0xFFFFFFFF, remainder 5, ready on edge 2.
- Abandon at edge 10 of a run → next edge IDLE with ready=0, busy=0, res=0. A new start on the following cycle gives the correct result with full latency.
- Reset and operand stability:
  - rst low mid-RUN → all outputs 0 immediately.
  - Changing opr1/opr2 after edge 0 → result unaffected.
  - WIDTH=8 instance: 0xF6 / 0x03 signed → quotient 0xFD, remainder 0xFF.

Source files
------------

// File: rtl/divider_param.sv
// Iterative radix-2 restoring divider with generic width, optional leading-zero early-out,
// latched operands, a defined divide-by-zero result and a busy indicator.
module divider_param #(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abandon,
    input  logic                 signdiv,
    input  logic [WIDTH-1:0]     opr1,
    input  logic [WIDTH-1:0]     opr2,
    output logic                 ready,
    output logic                 busy,
    output logic                 dbz,
    output logic [2*WIDTH-1:0]   res
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] orig;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             neg_a;
    logic             neg_b;
    logic             zero_div;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [CW-1:0]    shift_amt;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    function automatic logic [CW-1:0] clz(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = CW'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CW'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    always_comb begin
        mag1      = (signdiv && opr1[WIDTH-1]) ? (~opr1 + 1'b1) : opr1;
        mag2      = (signdiv && opr2[WIDTH-1]) ? (~opr2 + 1'b1) : opr2;
        shift_amt = (EARLY_OUT != 0) ? clz(dvd) : '0;
        rem_sh    = {rem, dvd[WIDTH-1]};
        fits      = (rem_sh >= {1'b0, dvs});
        // The restored remainder is always below the divisor, so the low bits of the difference are exact.
        diff      = rem_sh[WIDTH-1:0] - dvs;
        quo_fix   = (neg_a ^ neg_b) ? (~dvd + 1'b1) : dvd;
        rem_fix   = neg_a ? (~rem + 1'b1) : rem;
        if (zero_div) begin
            quo_fix = '1;
            rem_fix = orig;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abandon) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = PREP;
                PREP: begin
                    if (dvs == '0)                  state_nxt = FIX;
                    else if (shift_amt == CW'(WIDTH)) state_nxt = FIX;
                    else                            state_nxt = RUN;
                end
                RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (!start) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd      <= '0;
            dvs      <= '0;
            orig     <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            zero_div <= 1'b0;
            ready    <= 1'b0;
            dbz      <= 1'b0;
            res      <= '0;
        end else if (abandon) begin
            ready <= 1'b0;
            dbz   <= 1'b0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd      <= mag1;
                        dvs      <= mag2;
                        orig     <= opr1;
                        neg_a    <= signdiv & opr1[WIDTH-1];
                        neg_b    <= signdiv & opr2[WIDTH-1];
                        rem      <= '0;
                        cnt      <= '0;
                        zero_div <= 1'b0;
                    end
                end
                PREP: begin
                    rem <= '0;
                    if (dvs == '0) begin
                        zero_div <= 1'b1;
                    end else begin
                        dvd <= dvd << shift_amt;
                        cnt <= shift_amt;
                    end
                end
                RUN: begin
                    // The dividend register doubles as the quotient shift register.
                    rem <= fits ? diff : rem_sh[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    res   <= {rem_fix, quo_fix};
                    dbz   <= zero_div;
                    ready <= 1'b1;
                end
                DONE: begin
                    if (!start) begin
                        ready <= 1'b0;
                        dbz   <= 1'b0;
                        res   <= '0;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    dbz   <= 1'b0;
                    res   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_param.sv
// Scoreboard bench for divider_param: three instances (32-bit full run, 32-bit early-out, 8-bit early-out).
module tb_divider_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v   [3];
    logic        abandon_v [3];
    logic        signdiv_v [3];
    logic [31:0] a_v       [3];
    logic [31:0] b_v       [3];
    logic        ready_v   [3];
    logic        busy_v    [3];
    logic        dbz_v     [3];
    logic [63:0] res_a;
    logic [63:0] res_b;
    logic [15:0] res_c;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          sel;
        logic [63:0] res;
        logic        dbz;
        int          edge0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   prev_rdy [3];

    divider_param #(.WIDTH(32), .EARLY_OUT(0)) u_full (
        .clk(clk), .rst(rst), .start(start_v[0]), .abandon(abandon_v[0]), .signdiv(signdiv_v[0]),
        .opr1(a_v[0]), .opr2(b_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .dbz(dbz_v[0]), .res(res_a)
    );

    divider_param #(.WIDTH(32), .EARLY_OUT(1)) u_early (
        .clk(clk), .rst(rst), .start(start_v[1]), .abandon(abandon_v[1]), .signdiv(signdiv_v[1]),
        .opr1(a_v[1]), .opr2(b_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .dbz(dbz_v[1]), .res(res_b)
    );

    divider_param #(.WIDTH(8), .EARLY_OUT(1)) u_small (
        .clk(clk), .rst(rst), .start(start_v[2]), .abandon(abandon_v[2]), .signdiv(signdiv_v[2]),
        .opr1(a_v[2][7:0]), .opr2(b_v[2][7:0]), .ready(ready_v[2]), .busy(busy_v[2]), .dbz(dbz_v[2]), .res(res_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] res_of(input int sel);
        case (sel)
            0:       return res_a;
            1:       return res_b;
            default: return {48'h0, res_c};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising ready pops the oldest expectation and checks result, flag and latency.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready_v[i] && !prev_rdy[i]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_result dut%0d: got %h expected no result", i, res_of(i));
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("sb_dut", 64'(i), 64'(mon_e.sel));
                    checkOutput("sb_res", res_of(i), mon_e.res);
                    checkOutput("sb_dbz", 64'(dbz_v[i]), 64'(mon_e.dbz));
                    checkOutput("sb_latency", 64'(cyc - mon_e.edge0), 64'(mon_e.lat));
                end
            end
            prev_rdy[i] = ready_v[i];
        end
    end

    // Called at a negedge; returns at a negedge after the result has been released.
    task automatic applyStimulus(input int sel, input logic sd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] er, input logic ed, input int lat, input bit scramble);
        exp_t e;
        int   n;
        start_v[sel]   = 1'b1;
        signdiv_v[sel] = sd;
        a_v[sel]       = a;
        b_v[sel]       = b;
        e.sel   = sel;
        e.res   = er;
        e.dbz   = ed;
        e.edge0 = cyc + 1;
        e.lat   = lat;
        sb.push_back(e);
        @(negedge clk);
        if (scramble) begin
            a_v[sel]       = ~a;
            b_v[sel]       = 32'h3;
            signdiv_v[sel] = ~sd;
        end
        n = 0;
        while (!ready_v[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_v[sel]) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout dut%0d: got ready=0 expected ready=1", sel);
            sb.delete();
        end else begin
            repeat (2) @(negedge clk);
            checkOutput("hold_ready", 64'(ready_v[sel]), 64'd1);
            checkOutput("hold_res", res_of(sel), er);
        end
        start_v[sel] = 1'b0;
        @(negedge clk);
        checkOutput("clear_ready", 64'(ready_v[sel]), 64'd0);
        checkOutput("clear_busy", 64'(busy_v[sel]), 64'd0);
        checkOutput("clear_dbz", 64'(dbz_v[sel]), 64'd0);
        checkOutput("clear_res", res_of(sel), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            abandon_v[i] = 1'b0;
            signdiv_v[i] = 1'b0;
            a_v[i]       = '0;
            b_v[i]       = '0;
            prev_rdy[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_ready", 64'(ready_v[i]), 64'd0);
            checkOutput("reset_busy", 64'(busy_v[i]), 64'd0);
            checkOutput("reset_res", res_of(i), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(0, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 34, 1'b0);
        applyStimulus(1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 9, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 32'd3, 64'd0, 1'b0, 2, 1'b0);
        applyStimulus(1, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 5, 1'b0);
        applyStimulus(1, 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, 5, 1'b0);
        applyStimulus(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 34, 1'b0);
        applyStimulus(1, 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 2, 1'b0);
        applyStimulus(0, 1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 2, 1'b0);
        applyStimulus(1, 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, 2, 1'b0);

        // Abandon after edge 10 of a full-length run, then restart on the next cycle.
        start_v[0]   = 1'b1;
        signdiv_v[0] = 1'b0;
        a_v[0]       = 32'd100;
        b_v[0]       = 32'd7;
        repeat (10) @(negedge clk);
        checkOutput("busy_before_abandon", 64'(busy_v[0]), 64'd1);
        abandon_v[0] = 1'b1;
        start_v[0]   = 1'b0;
        @(negedge clk);
        checkOutput("abandon_ready", 64'(ready_v[0]), 64'd0);
        checkOutput("abandon_busy", 64'(busy_v[0]), 64'd0);
        checkOutput("abandon_res", res_a, 64'd0);
        abandon_v[0] = 1'b0;
        applyStimulus(0, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 34, 1'b0);

        applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0, 34, 1'b1);
        applyStimulus(2, 1'b1, 32'h0000_00F6, 32'h0000_0003, 64'h0000_0000_0000_FFFD, 1'b0, 6, 1'b1);
        applyStimulus(2, 1'b0, 32'h0000_00FF, 32'h0000_0001, 64'h0000_0000_0000_00FF, 1'b0, 10, 1'b0);

        // Asynchronous reset in the middle of a run.
        start_v[0]   = 1'b1;
        signdiv_v[0] = 1'b0;
        a_v[0]       = 32'd1000;
        b_v[0]       = 32'd9;
        repeat (6) @(negedge clk);
        checkOutput("busy_before_reset", 64'(busy_v[0]), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrun_reset_busy", 64'(busy_v[0]), 64'd0);
        checkOutput("midrun_reset_ready", 64'(ready_v[0]), 64'd0);
        checkOutput("midrun_reset_dbz", 64'(dbz_v[0]), 64'd0);
        checkOutput("midrun_reset_res", res_a, 64'd0);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
